// File: rtl/calc_pkg.sv
// Shared constants for the sequential multiplier.
//   S_IDLE / S_RUN / S_DONE : FSM state encodings (2'b11 is unused)
//   ITER                    : number of shift-add iterations per product
//   LAST_CNT                : iteration counter value in the final RUN cycle
package calc_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam int unsigned ITER     = 8;
  localparam logic [3:0]  LAST_CNT = 4'(ITER - 1);

endpackage

// File: rtl/FullAdder_8bit.sv
// 8-bit ripple-carry adder.
//   a, b    : 8-bit addends
//   sel     : carry-in
//   s0..s7  : sum bits, s0 is the LSB
//   co      : carry-out of bit 7
module FullAdder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sel,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       s4,
  output logic       s5,
  output logic       s6,
  output logic       s7,
  output logic       co
);

  logic [8:0] c;
  logic [7:0] s;

  assign c[0] = sel;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign {s7, s6, s5, s4, s3, s2, s1, s0} = s;
  assign co = c[8];

endmodule

// File: rtl/mult_seq_8bit.sv
// Sequential shift-and-add 8x8 unsigned multiplier.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : request, sampled only when idle
//   a, b   : multiplicand / multiplier, captured on an accepted start
//   busy   : high while running and during the done cycle
//   done   : one-cycle completion pulse
//   p      : 16-bit product
// WIDTH must be 8 (the shared adder is fixed at 8 bits).
module mult_seq_8bit
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          HOLD_RESULT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [7:0] add_b;
  logic [7:0] sum;
  logic       cout;

  assign add_b = q_q[0] ? m_q : '0;

  FullAdder_8bit u_add (
    .a   (acc_q),
    .b   (add_b),
    .sel (1'b0),
    .s0  (sum[0]),
    .s1  (sum[1]),
    .s2  (sum[2]),
    .s3  (sum[3]),
    .s4  (sum[4]),
    .s5  (sum[5]),
    .s6  (sum[6]),
    .s7  (sum[7]),
    .co  (cout)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // {C,S,Q} shifted right one place: carry becomes the new A MSB.
        acc_d = {cout, sum[7:1]};
        q_d   = {sum[0], q_q[7:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          // Product register loads on the edge entering DONE so it is
          // already valid while done is high.
          p_d     = {cout, sum, q_q[7:1]};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_DONE);
  assign done = (state_q == S_DONE);
  assign p    = (!HOLD_RESULT && state_q == S_RUN) ? '0 : p_q;

endmodule

// File: tb/tb_mult_seq_8bit.sv
module tb_mult_seq_8bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] p;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  mult_seq_8bit #(.WIDTH(8), .HOLD_RESULT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending product.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got p=0x%0h with no product pending", p);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (p !== e) begin
          n_fail++;
          $display("FAIL product: got 0x%0h expected 0x%0h", p, e);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation, push its product, check latency and return to idle.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] expv,
                        input bit detail);
    int lat;
    wait_idle();
    a = va;
    b = vb;
    start = 1'b1;
    exp_q.push_back(expv);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) begin
        start = 1'b0;
        a = ~va;
        b = ~vb;
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (detail || lat != 9) chk("latency", 32'(lat), 32'd9);
    if (detail) begin
      tick();
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("p_hold_idle", 32'(p), 32'(expv));
    end
  endtask

  initial begin
    int ndone;
    int last_done;
    int intervals_ok;
    logic [7:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;

    // 1. reset
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_p",    32'(p),    32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_done", 32'(done), 32'd0);
    chk("rel_p",    32'(p),    32'd0);

    // 2./3. directed products
    run_op(8'd13,  8'd11,  16'd143,   1'b1);
    run_op(8'hFF,  8'hFF,  16'hFE01,  1'b1);
    run_op(8'h00,  8'hA5,  16'h0000,  1'b1);
    run_op(8'h80,  8'h02,  16'h0100,  1'b1);
    run_op(8'h01,  8'hFF,  16'h00FF,  1'b0);
    run_op(8'hFF,  8'h01,  16'h00FF,  1'b0);
    run_op(8'h0F,  8'h10,  16'h00F0,  1'b0);

    // 4. start ignored while busy (mid-RUN and during DONE)
    wait_idle();
    a = 8'd3;
    b = 8'd5;
    start = 1'b1;
    exp_q.push_back(16'd15);
    ndone = 0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        start = 1'b1;
        a = 8'd7;
        b = 8'd7;
      end else if (n == 4) begin
        start = 1'b1;
        a = 8'd7;
        b = 8'd7;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_ignore_done_count", 32'(ndone), 32'd1);
    chk("busy_ignore_idle", 32'(busy), 32'd0);
    chk("busy_ignore_p", 32'(p), 32'd15);

    // 5. reset aborts a running operation
    wait_idle();
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    chk("abort_running", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_p",    32'(p),    32'd0);
    for (int n = 0; n < 12; n++) tick();
    chk("abort_stays_idle", 32'(busy), 32'd0);
    run_op(8'd6, 8'd7, 16'd42, 1'b1);

    // 6. start held high: back-to-back operations every 10 cycles
    wait_idle();
    a = 8'd9;
    b = 8'd9;
    for (int k = 0; k < 4; k++) exp_q.push_back(16'd81);
    start = 1'b1;
    ndone = 0;
    last_done = 0;
    intervals_ok = 0;
    for (int n = 1; n <= 60 && ndone < 4; n++) begin
      tick();
      if (done === 1'b1) begin
        if (ndone > 0 && (n - last_done) == 10) intervals_ok++;
        ndone++;
        last_done = n;
        if (ndone == 4) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_start_dones", 32'(ndone), 32'd4);
    chk("held_start_interval", 32'(intervals_ok), 32'd3);

    // Random operands, expected product computed here
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 16'(ra) * 16'(rb), 1'b0);
    end
    wait_idle();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
